sr_595_rx: RTL and testbench
============================

Name: sr_595_rx

Overview:
- Receive end of the 74595 PMOD serial protocol: SER, SRCLK, RCLK/latch, OE and the 4 one-hot row lines.
- Samples the pins as an independent receiver and reproduces the chain's shift and storage registers in the FPGA clock domain.
- Files each latched word into a row-indexed frame store and flags malformed transfers.
- Used as a loopback monitor for the display driver, and as a slave when a second board emulates the PMOD.

Parameters:
- WIDTH, 8, bits per latched word (595 chain length × 8).
- ROWS, 4, number of row lines / frame-store entries; must be a power of 2, ≥2.
- SYNC_STAGES, 2, synchroniser flops per input pin (≥2).

Ports:
- clk_16mhz  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- sr_clk  input  1  serial shift clock pin (async to clk_16mhz).
- sr_ser  input  1  serial data pin.
- sr_lat  input  1  storage latch pin; rising edge commits.
- sr_oe  input  1  output-enable pin, passed through as a status flag.
- line  input  ROWS  one-hot row select pins.
- word_q  output  WIDTH  last committed storage word.
- word_row  output  $clog2(ROWS)  row index of word_q.
- word_valid  output  1  one-cycle pulse on each good commit.
- oe_q  output  1  synchronised sr_oe.
- row_err  output  1  one-cycle pulse: latch with line not one-hot.
- len_err  output  1  one-cycle pulse: latch after bit count ≠ WIDTH.
- rd_row  input  $clog2(ROWS)  frame-store read address.
- rd_data  output  WIDTH  frame-store data, combinational from rd_row.

Behaviour:
- Reset (async assert, sync release) clears:
  - word_q, word_row, shift register and all frame rows to 0;
  - word_valid, row_err, len_err and oe_q to 0;
  - bit counter to 0;
  - synchroniser and edge-history flops to 0.
- All pins pass through SYNC_STAGES flops. An extra history flop feeds the rising-edge detectors on sr_clk and sr_lat.
- Each pin phase must be stable for ≥2 clk_16mhz cycles; shorter pulses may be missed. A driver at clk/4 (2 high, 2 low) is the minimum supported rate.
- Shift, on sr_clk rise:
  - sh <= {sh[WIDTH-2:0], ser_s}; the first bit sent ends in bit WIDTH-1 after WIDTH shifts.
  - Bit counter increments and saturates at 2^($clog2(WIDTH)+1)-1; no wrap.
- Commit, on sr_lat rise:
  - word_q <= sh and word_row <= encode(line_s); bit counter clears.
  - If line_s is one-hot: frame[word_row] <= sh, and word_valid pulses in the cycle after the detected edge.
  - If line_s is zero or multi-hot: word_q still updates, word_row and frame are unchanged, row_err pulses, word_valid stays 0.
  - If bit count ≠ WIDTH: len_err pulses. The commit still proceeds per the row rule, matching 595 semantics.
- Simultaneous sr_clk and sr_lat rise in one sample:
  - Latch captures the pre-shift sh; the shift then takes effect.
  - Bit counter is set to 1, not 0.
  - This mirrors tied SRCLK/RCLK on a real 595, where storage runs one bit behind.
- Latency: pin edge to word_valid = SYNC_STAGES + 2 clk cycles, fixed.
- oe_q follows sr_oe after SYNC_STAGES cycles. It does not gate commits or word_q.
- rd_data is combinational from the frame store. A read of the row being written returns the old value in the write cycle and the new value from the next cycle.
- rst_n asserted mid-word: partial shift contents are discarded and no pulse is produced. The first latch after release flags len_err unless exactly WIDTH bits have arrived since.

Decomposition:
- Shared package sr_595_pkg: default WIDTH/ROWS, and a one-hot check / encoder function reused by the driver and its bench.
- One sub-module, sr_sync_edge: parameterised N-stage synchroniser with rising-edge pulse output, instantiated once per sampled pin group.

Test Plan:
- Reset then idle 100 cycles → all outputs 0; rd_data = 0 for every rd_row.
- Drive at clk/4: 8 bits 1,0,1,0,0,1,1,0 (first to last), line = 4'b0100, latch → word_q = 8'hA6, word_row = 2, word_valid pulses once at edge + 4; rd_row = 2 gives 8'hA6.
- Latch with line = 4'b0101 after 8 bits 8'hFF → row_err pulses, word_q = 8'hFF, frame unchanged, no word_valid.
- Only 5 bits then latch, line = 4'b0001 → len_err and word_valid both pulse; word_q = 5 bits in the low bits over prior bits shifted up.
- sr_clk and sr_lat rising together after 8 bits 8'h3C → word_q = 8'h3C (pre-shift); the next 7 shifts plus latch commits a full word with no len_err.
- Assert rst_n after 4 bits mid-word, release, send 8 bits 8'h81 to row 3 → word_q = 8'h81, no len_err, frame[3] = 8'h81.

Source files
------------

// File: rtl/sr_595_pkg.sv
// Shared defaults and row-line helpers for the 74595 PMOD link (driver, receiver, benches).
package sr_595_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_ROWS  = 4;
    localparam int MAX_ROWS  = 32;
    localparam int ROW_IDX_W = $clog2(MAX_ROWS);

    // Callers zero-extend their row vector to MAX_ROWS bits.
    function automatic logic is_onehot(input logic [MAX_ROWS-1:0] v);
        return (v != '0) && ((v & (v - MAX_ROWS'(1))) == '0);
    endfunction

    function automatic logic [ROW_IDX_W-1:0] onehot_encode(input logic [MAX_ROWS-1:0] v);
        logic [ROW_IDX_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < MAX_ROWS; i++) begin
            if (v[i]) idx = idx | ROW_IDX_W'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/sr_sync_edge.sv
// N-bit pin synchroniser. Output is either a registered rising-edge pulse, the level delayed
// to line up with that pulse, or the plain synchronised level.
module sr_sync_edge #(
    parameter int N      = 1,
    parameter int STAGES = 2,
    parameter bit EDGE   = 1'b0,
    parameter bit ALIGN  = 1'b1
) (
    input  logic         clk_16mhz,
    input  logic         rst_n,
    input  logic [N-1:0] pins,
    output logic [N-1:0] q
);

    logic [STAGES*N-1:0] chain_reg;
    logic [N-1:0]        sync;

    always_ff @(posedge clk_16mhz or negedge rst_n) begin
        if (!rst_n) chain_reg <= '0;
        else        chain_reg <= {chain_reg[(STAGES-1)*N-1:0], pins};
    end

    assign sync = chain_reg[STAGES*N-1 -: N];

    generate
        if (EDGE) begin : g_edge
            logic [N-1:0] hist_reg;
            logic [N-1:0] rise_reg;
            always_ff @(posedge clk_16mhz or negedge rst_n) begin
                if (!rst_n) begin
                    hist_reg <= '0;
                    rise_reg <= '0;
                end else begin
                    hist_reg <= sync;
                    rise_reg <= sync & ~hist_reg;
                end
            end
            assign q = rise_reg;
        end else if (ALIGN) begin : g_align
            // One extra flop so data lines up with the registered edge pulses.
            logic [N-1:0] hist_reg;
            always_ff @(posedge clk_16mhz or negedge rst_n) begin
                if (!rst_n) hist_reg <= '0;
                else        hist_reg <= sync;
            end
            assign q = hist_reg;
        end else begin : g_level
            assign q = sync;
        end
    endgenerate

endmodule

// File: rtl/sr_595_rx.sv
// Receiver for the 74595 PMOD link: rebuilds shift/storage registers from the pins and files
// each latched word into a row-indexed frame store, flagging bad row selects and bit counts.
module sr_595_rx
    import sr_595_pkg::*;
#(
    parameter int WIDTH       = DEF_WIDTH,
    parameter int ROWS        = DEF_ROWS,
    parameter int SYNC_STAGES = 2
) (
    input  logic                    clk_16mhz,
    input  logic                    rst_n,
    input  logic                    sr_clk,
    input  logic                    sr_ser,
    input  logic                    sr_lat,
    input  logic                    sr_oe,
    input  logic [ROWS-1:0]         line,
    output logic [WIDTH-1:0]        word_q,
    output logic [$clog2(ROWS)-1:0] word_row,
    output logic                    word_valid,
    output logic                    oe_q,
    output logic                    row_err,
    output logic                    len_err,
    input  logic [$clog2(ROWS)-1:0] rd_row,
    output logic [WIDTH-1:0]        rd_data
);

    localparam int RW = $clog2(ROWS);
    localparam int CW = $clog2(WIDTH) + 1;

    logic [1:0]      edge_q;
    logic [ROWS:0]   data_q;
    logic            clk_rise, lat_rise, ser_l;
    logic [ROWS-1:0] line_l;

    sr_sync_edge #(.N(2), .STAGES(SYNC_STAGES), .EDGE(1'b1), .ALIGN(1'b1)) u_edge (
        .clk_16mhz (clk_16mhz),
        .rst_n     (rst_n),
        .pins      ({sr_lat, sr_clk}),
        .q         (edge_q)
    );

    sr_sync_edge #(.N(ROWS + 1), .STAGES(SYNC_STAGES), .EDGE(1'b0), .ALIGN(1'b1)) u_data (
        .clk_16mhz (clk_16mhz),
        .rst_n     (rst_n),
        .pins      ({line, sr_ser}),
        .q         (data_q)
    );

    sr_sync_edge #(.N(1), .STAGES(SYNC_STAGES), .EDGE(1'b0), .ALIGN(1'b0)) u_oe (
        .clk_16mhz (clk_16mhz),
        .rst_n     (rst_n),
        .pins      (sr_oe),
        .q         (oe_q)
    );

    assign clk_rise = edge_q[0];
    assign lat_rise = edge_q[1];
    assign ser_l    = data_q[0];
    assign line_l   = data_q[ROWS:1];

    logic          row_ok;
    logic [RW-1:0] row_idx;

    assign row_ok  = is_onehot(MAX_ROWS'(line_l));
    assign row_idx = RW'(onehot_encode(MAX_ROWS'(line_l)));

    logic [WIDTH-1:0] sh_reg;
    logic [WIDTH-1:0] word_q_reg;
    logic [RW-1:0]    word_row_reg;
    logic             word_valid_reg, row_err_reg, len_err_reg;
    logic [CW-1:0]    bit_cnt_reg;

    always_ff @(posedge clk_16mhz or negedge rst_n) begin
        if (!rst_n) begin
            sh_reg         <= '0;
            word_q_reg     <= '0;
            word_row_reg   <= '0;
            word_valid_reg <= 1'b0;
            row_err_reg    <= 1'b0;
            len_err_reg    <= 1'b0;
            bit_cnt_reg    <= '0;
        end else begin
            word_valid_reg <= 1'b0;
            row_err_reg    <= 1'b0;
            len_err_reg    <= 1'b0;
            if (clk_rise) sh_reg <= {sh_reg[WIDTH-2:0], ser_l};
            if (lat_rise) begin
                // Latch takes the pre-shift word; a coincident shift counts as the next word's first bit.
                word_q_reg  <= sh_reg;
                bit_cnt_reg <= clk_rise ? CW'(1) : '0;
                len_err_reg <= (bit_cnt_reg != CW'(WIDTH));
                if (row_ok) begin
                    word_row_reg   <= row_idx;
                    word_valid_reg <= 1'b1;
                end else begin
                    row_err_reg <= 1'b1;
                end
            end else if (clk_rise && (bit_cnt_reg != '1)) begin
                bit_cnt_reg <= bit_cnt_reg + CW'(1);
            end
        end
    end

    logic [WIDTH-1:0] row_data [ROWS];

    generate
        for (genvar gi = 0; gi < ROWS; gi++) begin : g_row
            logic [WIDTH-1:0] row_reg;
            always_ff @(posedge clk_16mhz or negedge rst_n) begin
                if (!rst_n)                                           row_reg <= '0;
                else if (lat_rise && row_ok && (row_idx == RW'(gi)))  row_reg <= sh_reg;
            end
            assign row_data[gi] = row_reg;
        end
    endgenerate

    assign rd_data    = row_data[rd_row];
    assign word_q     = word_q_reg;
    assign word_row   = word_row_reg;
    assign word_valid = word_valid_reg;
    assign row_err    = row_err_reg;
    assign len_err    = len_err_reg;

endmodule

// File: tb/tb_sr_595_rx.sv
// Directed bench for sr_595_rx: drives the PMOD pins at clk/4 and checks words, rows and pulses.
`timescale 1ns/1ps
module tb_sr_595_rx;

    logic       clk_16mhz;
    logic       rst_n;
    logic       sr_clk, sr_ser, sr_lat, sr_oe;
    logic [3:0] line;
    logic [7:0] word_q;
    logic [1:0] word_row;
    logic       word_valid, oe_q, row_err, len_err;
    logic [1:0] rd_row;
    logic [7:0] rd_data;

    int errors = 0;
    int checks = 0;
    int vcnt, rcnt, lcnt, vfirst;

    sr_595_rx dut (
        .clk_16mhz  (clk_16mhz),
        .rst_n      (rst_n),
        .sr_clk     (sr_clk),
        .sr_ser     (sr_ser),
        .sr_lat     (sr_lat),
        .sr_oe      (sr_oe),
        .line       (line),
        .word_q     (word_q),
        .word_row   (word_row),
        .word_valid (word_valid),
        .oe_q       (oe_q),
        .row_err    (row_err),
        .len_err    (len_err),
        .rd_row     (rd_row),
        .rd_data    (rd_data)
    );

    initial begin
        clk_16mhz = 1'b0;
        forever #5 clk_16mhz = ~clk_16mhz;
    end

    // One bit at clk/4: 2 cycles low with data set up, then 2 cycles high.
    task automatic send_bit(input logic b);
        @(negedge clk_16mhz);
        sr_clk = 1'b0;
        sr_ser = b;
        @(negedge clk_16mhz);
        @(negedge clk_16mhz);
        sr_clk = 1'b1;
        @(negedge clk_16mhz);
    endtask

    task automatic send_bits(input logic [7:0] v, input int n);
        for (int i = 0; i < n; i++) send_bit(v[7-i]);
    endtask

    // Raise sr_lat (optionally together with sr_clk) and record output pulses for 6 cycles.
    task automatic pulse_latch(input logic with_clk, input logic ser_bit);
        @(negedge clk_16mhz);
        sr_clk = 1'b0;
        if (with_clk) sr_ser = ser_bit;
        @(negedge clk_16mhz);
        @(negedge clk_16mhz);
        sr_lat = 1'b1;
        if (with_clk) sr_clk = 1'b1;
        vcnt = 0; rcnt = 0; lcnt = 0; vfirst = -1;
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk_16mhz);
            if (word_valid) begin
                vcnt++;
                if (vfirst < 0) vfirst = i;
            end
            if (row_err) rcnt++;
            if (len_err) lcnt++;
        end
        sr_lat = 1'b0;
        @(negedge clk_16mhz);
        @(negedge clk_16mhz);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; sr_clk = 1'b0; sr_ser = 1'b0; sr_lat = 1'b0; sr_oe = 1'b0;
        line = 4'b0000; rd_row = 2'd0;
        repeat (3) @(negedge clk_16mhz);
        rst_n = 1'b1;
        repeat (100) @(negedge clk_16mhz);
        checks++; if (word_q !== 8'h00) begin errors++; $display("FAIL reset_word_q: got %h expected 00", word_q); end
        checks++; if (word_row !== 2'd0) begin errors++; $display("FAIL reset_word_row: got %0d expected 0", word_row); end
        checks++; if ({word_valid, row_err, len_err, oe_q} !== 4'b0000) begin
            errors++; $display("FAIL reset_flags: got %b expected 0000", {word_valid, row_err, len_err, oe_q});
        end
        for (int r = 0; r < 4; r++) begin
            rd_row = 2'(r);
            #1;
            checks++; if (rd_data !== 8'h00) begin errors++; $display("FAIL reset_frame row %0d: got %h expected 00", r, rd_data); end
        end
        $display("reset: done");
    endtask

    task automatic test_oe();
        @(negedge clk_16mhz);
        sr_oe = 1'b1;
        @(negedge clk_16mhz);
        checks++; if (oe_q !== 1'b0) begin errors++; $display("FAIL oe_early: got %b expected 0", oe_q); end
        @(negedge clk_16mhz);
        checks++; if (oe_q !== 1'b1) begin errors++; $display("FAIL oe_rise: got %b expected 1", oe_q); end
        sr_oe = 1'b0;
        repeat (3) @(negedge clk_16mhz);
        checks++; if (oe_q !== 1'b0) begin errors++; $display("FAIL oe_fall: got %b expected 0", oe_q); end
        $display("oe: passthrough sampled");
    endtask

    task automatic test_basic_word();
        line = 4'b0100;
        send_bits(8'hA6, 8);
        pulse_latch(1'b0, 1'b0);
        checks++; if (word_q !== 8'hA6) begin errors++; $display("FAIL basic_word_q: got %h expected a6", word_q); end
        checks++; if (word_row !== 2'd2) begin errors++; $display("FAIL basic_word_row: got %0d expected 2", word_row); end
        checks++; if (vcnt != 1) begin errors++; $display("FAIL basic_valid_count: got %0d expected 1", vcnt); end
        checks++; if (vfirst != 4) begin errors++; $display("FAIL basic_latency: got %0d expected 4", vfirst); end
        checks++; if (rcnt != 0 || lcnt != 0) begin errors++; $display("FAIL basic_errs: got row=%0d len=%0d expected 0/0", rcnt, lcnt); end
        rd_row = 2'd2; #1;
        checks++; if (rd_data !== 8'hA6) begin errors++; $display("FAIL basic_frame2: got %h expected a6", rd_data); end
        $display("basic: word=%h row=%0d valid_at=%0d", word_q, word_row, vfirst);
    endtask

    task automatic test_row_err();
        line = 4'b0101;
        send_bits(8'hFF, 8);
        pulse_latch(1'b0, 1'b0);
        checks++; if (rcnt != 1) begin errors++; $display("FAIL rowerr_pulse: got %0d expected 1", rcnt); end
        checks++; if (vcnt != 0 || lcnt != 0) begin errors++; $display("FAIL rowerr_others: got valid=%0d len=%0d expected 0/0", vcnt, lcnt); end
        checks++; if (word_q !== 8'hFF) begin errors++; $display("FAIL rowerr_word_q: got %h expected ff", word_q); end
        checks++; if (word_row !== 2'd2) begin errors++; $display("FAIL rowerr_word_row: got %0d expected 2", word_row); end
        rd_row = 2'd2; #1;
        checks++; if (rd_data !== 8'hA6) begin errors++; $display("FAIL rowerr_frame2: got %h expected a6", rd_data); end
        rd_row = 2'd0; #1;
        checks++; if (rd_data !== 8'h00) begin errors++; $display("FAIL rowerr_frame0: got %h expected 00", rd_data); end
        $display("row_err: word=%h row_err=%0d", word_q, rcnt);
    endtask

    task automatic test_len_err();
        // Bits 1,0,1,1,0 onto sh=ff gives {111,10110} = f6.
        line = 4'b0001;
        send_bits(8'hB0, 5);
        pulse_latch(1'b0, 1'b0);
        checks++; if (lcnt != 1) begin errors++; $display("FAIL len_pulse: got %0d expected 1", lcnt); end
        checks++; if (vcnt != 1) begin errors++; $display("FAIL len_valid: got %0d expected 1", vcnt); end
        checks++; if (word_q !== 8'hF6) begin errors++; $display("FAIL len_word_q: got %h expected f6", word_q); end
        checks++; if (word_row !== 2'd0) begin errors++; $display("FAIL len_word_row: got %0d expected 0", word_row); end
        rd_row = 2'd0; #1;
        checks++; if (rd_data !== 8'hF6) begin errors++; $display("FAIL len_frame0: got %h expected f6", rd_data); end
        $display("len_err: word=%h len_err=%0d", word_q, lcnt);
    endtask

    task automatic test_back_to_back();
        // Tied SRCLK/RCLK edge: commit 3c, and the coincident bit starts word 5a.
        line = 4'b0010;
        send_bits(8'h3C, 8);
        pulse_latch(1'b1, 1'b0);
        checks++; if (word_q !== 8'h3C) begin errors++; $display("FAIL simul_word_q: got %h expected 3c", word_q); end
        checks++; if (word_row !== 2'd1) begin errors++; $display("FAIL simul_word_row: got %0d expected 1", word_row); end
        checks++; if (vcnt != 1 || lcnt != 0) begin errors++; $display("FAIL simul_pulses: got valid=%0d len=%0d expected 1/0", vcnt, lcnt); end
        send_bits(8'hB4, 7);
        pulse_latch(1'b0, 1'b0);
        checks++; if (word_q !== 8'h5A) begin errors++; $display("FAIL simul_next_word_q: got %h expected 5a", word_q); end
        checks++; if (lcnt != 0) begin errors++; $display("FAIL simul_next_len: got %0d expected 0", lcnt); end
        checks++; if (vcnt != 1) begin errors++; $display("FAIL simul_next_valid: got %0d expected 1", vcnt); end
        rd_row = 2'd1; #1;
        checks++; if (rd_data !== 8'h5A) begin errors++; $display("FAIL simul_frame1: got %h expected 5a", rd_data); end
        $display("back_to_back: word=%h row=%0d", word_q, word_row);
    endtask

    task automatic test_reset_midword();
        int pulses;
        line = 4'b1000;
        send_bits(8'hF0, 4);
        @(negedge clk_16mhz);
        sr_clk = 1'b0;
        repeat (2) @(negedge clk_16mhz);
        rst_n = 1'b0;
        repeat (3) @(negedge clk_16mhz);
        checks++; if (word_q !== 8'h00) begin errors++; $display("FAIL midrst_word_q: got %h expected 00", word_q); end
        rst_n = 1'b1;
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk_16mhz);
            if (word_valid || row_err || len_err) pulses++;
        end
        checks++; if (pulses != 0) begin errors++; $display("FAIL midrst_no_pulse: got %0d expected 0", pulses); end
        send_bits(8'h81, 8);
        pulse_latch(1'b0, 1'b0);
        checks++; if (word_q !== 8'h81) begin errors++; $display("FAIL midrst_word_q2: got %h expected 81", word_q); end
        checks++; if (word_row !== 2'd3) begin errors++; $display("FAIL midrst_word_row: got %0d expected 3", word_row); end
        checks++; if (lcnt != 0 || vcnt != 1) begin errors++; $display("FAIL midrst_pulses: got len=%0d valid=%0d expected 0/1", lcnt, vcnt); end
        rd_row = 2'd3; #1;
        checks++; if (rd_data !== 8'h81) begin errors++; $display("FAIL midrst_frame3: got %h expected 81", rd_data); end
        rd_row = 2'd2; #1;
        checks++; if (rd_data !== 8'h00) begin errors++; $display("FAIL midrst_frame2_cleared: got %h expected 00", rd_data); end
        $display("reset_midword: word=%h row=%0d", word_q, word_row);
    endtask

    initial begin
        test_reset();
        test_oe();
        test_basic_word();
        test_row_err();
        test_len_err();
        test_back_to_back();
        test_reset_midword();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
